// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache way storage: flag bit positions and the
// sweep FSM state encoding.
package dcache_pkg;

  localparam int unsigned DCACHE_FLAG_VALID = 0;
  localparam int unsigned DCACHE_FLAG_DIRTY = 1;

  typedef enum logic [0:0] {
    DWR_IDLE,
    DWR_SWEEP
  } dwr_state_e;

endpackage

// File: rtl/dcache_way_bank.sv
// One cache way: single-port, read-first DEPTH x (PAY_W + FLAG_W) storage with
// byte-enabled payload writes and an independent flag write enable.
module dcache_way_bank #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned PAY_W  = 80,
  parameter int unsigned FLAG_W = 2,
  parameter int unsigned BE_W   = PAY_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              pay_we,
  input  logic [BE_W-1:0]   be,
  input  logic              flag_we,
  input  logic [PAY_W-1:0]  wdata,
  input  logic [FLAG_W-1:0] wflags,
  output logic [PAY_W-1:0]  rdata,
  output logic [FLAG_W-1:0] rflags
);

  logic [PAY_W-1:0]  pay_mem  [DEPTH];
  logic [FLAG_W-1:0] flag_mem [DEPTH];

  // Array contents carry no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (pay_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) begin
          pay_mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (flag_we) begin
      flag_mem[addr] <= wflags;
    end
  end

  // Non-blocking read of the array before the write lands gives read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rflags <= '0;
    end else if (rd_en) begin
      rdata  <= pay_mem[addr];
      rflags <= flag_mem[addr];
    end
  end

endmodule

// File: rtl/dcache_way_ram.sv
// Multi-way data-cache storage: WAYS read-first banks sharing one row address, with a
// sequential flag-clearing sweep after reset or on an invalidate-all pulse.
module dcache_way_ram
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned PAY_W  = 80,
  parameter int unsigned FLAG_W = 2,
  parameter int unsigned BE_W   = PAY_W / 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [WAYS-1:0]         i_way_we,
  input  logic [BE_W-1:0]         i_be,
  input  logic                    i_flag_we,
  input  logic [PAY_W-1:0]        i_data,
  input  logic [FLAG_W-1:0]       i_flags,
  input  logic                    i_inval_all,
  output logic [WAYS*PAY_W-1:0]   o_data,
  output logic [WAYS*FLAG_W-1:0]  o_flags,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned CNT_LAST = DEPTH - 1;

  dwr_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;

  logic              accept;
  logic              sweep_wr;
  logic [ADDR_W-1:0] bank_addr;
  logic [FLAG_W-1:0] bank_wflags;

  assign accept      = i_req && (state_q == DWR_IDLE);
  assign sweep_wr    = (state_q == DWR_SWEEP) && !i_rst;
  assign bank_addr   = (state_q == DWR_SWEEP) ? cnt_q[ADDR_W-1:0] : i_addr;
  assign bank_wflags = sweep_wr ? '0 : i_flags;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= DWR_SWEEP;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept;
      unique case (state_q)
        DWR_SWEEP: begin
          // Explicit terminal detect so the sweep never wraps back onto row 0.
          if (cnt_q == CNT_W'(CNT_LAST)) begin
            state_q <= DWR_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DWR_IDLE: begin
          // A request in the same cycle is still accepted; the sweep clears its flags later.
          if (i_inval_all) begin
            state_q <= DWR_SWEEP;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= DWR_SWEEP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_busy  = (state_q == DWR_SWEEP);

  for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
    dcache_way_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .PAY_W  (PAY_W),
      .FLAG_W (FLAG_W),
      .BE_W   (BE_W)
    ) u_bank (
      .clk     (i_clk),
      .rst     (i_rst),
      .rd_en   (accept),
      .addr    (bank_addr),
      .pay_we  (accept && i_way_we[w]),
      .be      (i_be),
      .flag_we (sweep_wr || (accept && i_way_we[w] && i_flag_we)),
      .wdata   (i_data),
      .wflags  (bank_wflags),
      .rdata   (o_data[w*PAY_W +: PAY_W]),
      .rflags  (o_flags[w*FLAG_W +: FLAG_W])
    );
  end

endmodule

// File: doc/dcache_way_ram.md
Name: dcache_way_ram

Overview:
- Parametrised multi-way storage array for the data cache. One row per set; each way holds a payload (tag + data) and a flag field.
- Adds the following over the single-way array:
  - N ways with per-way write enables.
  - Byte-enabled payload writes.
  - Separate flag-write control.
  - A sequential invalidate sweep instead of a one-cycle clear, so it maps onto SRAM macros.
- Sits between the dcache controller FSM and the RAM macros.

Parameters:
- WAYS, 2, number of ways.
- DEPTH, 64, rows per way; must be a power of two.
- ADDR_W, $clog2(DEPTH), row index width.
- PAY_W, 80, payload bits per way; must be a multiple of 8.
- FLAG_W, 2, flag bits per way (bit0 valid, bit1 dirty).
- BE_W, PAY_W/8, payload byte-enable width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  1  access request; accepted when i_req && !o_busy.
- i_addr  in  ADDR_W  row index.
- i_way_we  in  WAYS  per-way write enable (multi-hot allowed).
- i_be  in  BE_W  payload byte enables, shared by all written ways.
- i_flag_we  in  1  write flag field of the enabled ways.
- i_data  in  PAY_W  write payload.
- i_flags  in  FLAG_W  write flags.
- i_inval_all  in  1  pulse: clear all flags of every row and way.
- o_data  out  WAYS*PAY_W  read payloads; way w at [w*PAY_W +: PAY_W].
- o_flags  out  WAYS*FLAG_W  read flags; way w at [w*FLAG_W +: FLAG_W].
- o_valid  out  1  o_data/o_flags hold the result of the request accepted last cycle.
- o_busy  out  1  sweep in progress; requests are not accepted.

Behaviour:
- States: SWEEP, IDLE.
- Reset:
  - While i_rst is high: state=SWEEP, row counter=0, o_data=0, o_flags=0, o_valid=0, o_busy=1.
  - Payload contents are not reset.
- SWEEP:
  - Each cycle, flags of all ways at row[counter] are written to 0 and the counter increments.
  - After row DEPTH-1 is cleared: state becomes IDLE and o_busy falls. o_busy is therefore high for exactly DEPTH cycles after i_rst deasserts.
  - o_valid=0 and outputs hold 0 throughout.
  - i_rst mid-sweep restarts the counter at 0.
  - i_inval_all during SWEEP is ignored.
- IDLE, accepted request:
  - Read of row i_addr, all ways, 1-cycle latency: o_valid=1 on the next cycle.
  - For every way w with i_way_we[w]=1:
    - Payload byte b is updated iff i_be[b].
    - Flags are replaced by i_flags iff i_flag_we.
  - Read-during-write to the same row returns the OLD contents (read-first).
  - o_data/o_flags hold their value when no request is accepted; o_valid=0 in that case.
- i_inval_all in IDLE:
  - Enters SWEEP next cycle with counter=0; o_busy=1 from next cycle.
  - A request in the same cycle is still accepted and completes normally (o_valid next cycle). Its flag write is later cleared by the sweep.
- Counter width is ADDR_W+1 or uses explicit terminal detection; no wrap-around into row 0 after DEPTH-1.
- i_way_we=0 with i_req=1 is a pure read.
- i_flag_we=1 with i_be=0 is a flag-only update.

Decomposition:
- Package dcache_pkg holds:
  - DCACHE_FLAG_VALID=0, DCACHE_FLAG_DIRTY=1.
  - Sweep state enum {DWR_IDLE, DWR_SWEEP}.
- Sub-module dcache_way_bank: one way, single-port, read-first, DEPTH x (PAY_W+FLAG_W), byte-enable on payload and separate flag write enable. Instantiated WAYS times via generate.
- Top level holds the sweep FSM, counter, and address/write-enable muxing.

Test Plan:
- Reset sweep: pulse i_rst 2 cycles -> o_busy=1 for exactly 64 cycles after deassert. Read row 63 afterwards -> o_flags=0 for both ways.
- Way-selective write: i_way_we=2'b10, i_be=all ones, i_data=80'hA5..., i_flags=2'b11 at row 5; then read row 5 ->
  - way1 payload = written value, flags 2'b11;
  - way0 flags 2'b00.
- Byte enables: preload row 7 way0 with 0. Write i_data=all 0xFF with i_be=10'b0000000101, i_flag_we=0 -> read shows bytes 0 and 2 = 0xFF, the rest 0, flags unchanged.
- Read-first: write row 3 with X, then write row 3 with Y while reading -> o_data shows X with o_valid=1; next read shows Y.
- Invalidate race: set flags 2'b11 on rows 0 and 63. Assert i_inval_all together with a write to row 10 -> o_valid=1 next cycle, o_busy high 64 cycles, then all three rows read flags=0 while payloads are preserved.
- Reset mid-sweep: assert i_rst at sweep row 30 -> after deassert, o_busy high a full 64 cycles; requests during busy produce o_valid=0 and no writes.
